// File: rtl/noc_matmul_wrapper.sv
// Tiled signed matrix multiply D = A x B over a single-outstanding memory port.
// Latency: first request 2 cycles after start; each k step costs N1+N2+1 cycles at zero memory latency.
// Backpressure: request fields hold until mem_ready; reads wait for mem_rvalid. NOC_MM_SAT_EN selects saturating accumulation.
module noc_matmul_wrapper #(
  parameter int D_W          = 8,
  parameter int D_W_ACC      = 32,
  parameter int N1           = 2,
  parameter int N2           = 2,
  parameter int MATRIXSIZE_W = 24
) (
  input  logic                    clk_pl,
  input  logic                    rst_pl,
  input  logic                    start,
  output logic                    done,
  output logic                    error,
  input  logic [MATRIXSIZE_W-1:0] M1,
  input  logic [MATRIXSIZE_W-1:0] M2,
  input  logic [MATRIXSIZE_W-1:0] M3,
  input  logic [63:0]             addr_matrix_a,
  input  logic [63:0]             addr_matrix_b,
  input  logic [63:0]             addr_matrix_d,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [63:0]             mem_addr,
  output logic [D_W_ACC-1:0]      mem_wdata,
  input  logic                    mem_ready,
  input  logic                    mem_rvalid,
  input  logic [D_W-1:0]          mem_rdata,
  input  logic                    mem_err
);

  localparam int NC    = N1 * N2;
  localparam int IDX_W = $clog2(NC) + 1;
  localparam logic [IDX_W-1:0] LAST_A = IDX_W'(N1 - 1);
  localparam logic [IDX_W-1:0] LAST_B = IDX_W'(N2 - 1);
  localparam logic [IDX_W-1:0] LAST_D = IDX_W'(NC - 1);
  localparam logic [MATRIXSIZE_W-1:0] MS_N1 = MATRIXSIZE_W'(N1);
  localparam logic [MATRIXSIZE_W-1:0] MS_N2 = MATRIXSIZE_W'(N2);
  localparam logic [MATRIXSIZE_W-1:0] MS_1  = MATRIXSIZE_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD_A, S_LOAD_B, S_MAC, S_STORE, S_DONE} state_t;

  state_t                   state;
  logic [MATRIXSIZE_W-1:0]  m1_q, m2_q, m3_q, i0, j0, k;
  logic [63:0]              base_a, base_b, base_d;
  logic [IDX_W-1:0]         idx, nidx;
  logic                     wait_rv;
  logic signed [D_W-1:0]    a_reg [N1];
  logic signed [D_W-1:0]    b_reg [N2];
  logic signed [D_W_ACC-1:0] acc     [NC];
  logic signed [D_W_ACC-1:0] acc_nxt [NC];
  logic [D_W_ACC-1:0]       st_data;
  logic                     rd_take, rd_err, last_col, last_row;

  assign nidx     = idx + IDX_W'(1);
  assign last_col = (j0 + MS_N2 == m3_q);
  assign last_row = (i0 + MS_N1 == m1_q);

  function automatic logic [63:0] a_addr(input logic [MATRIXSIZE_W-1:0] i, input logic [MATRIXSIZE_W-1:0] kk);
    return base_a + 64'(i) * 64'(m2_q) + 64'(kk);
  endfunction

  function automatic logic [63:0] b_addr(input logic [MATRIXSIZE_W-1:0] kk, input logic [MATRIXSIZE_W-1:0] j);
    return base_b + 64'(kk) * 64'(m3_q) + 64'(j);
  endfunction

  // D element n of the current tile, row-major within the tile, 4-byte words
  function automatic logic [63:0] st_addr(input logic [IDX_W-1:0] n);
    logic [MATRIXSIZE_W-1:0] i, j;
    i = i0 + MATRIXSIZE_W'(int'(n) / N2);
    j = j0 + MATRIXSIZE_W'(int'(n) % N2);
    return base_d + ((64'(i) * 64'(m3_q) + 64'(j)) << 2);
  endfunction

  // Select the accumulator that the next store beat writes
  always_comb begin
    st_data = '0;
    for (int e = 0; e < NC; e++)
      if (nidx == IDX_W'(e)) st_data = acc[e];
  end

  // A read completes either with its acceptance or later on its own rvalid
  always_comb begin
    rd_take = wait_rv ? mem_rvalid : (mem_ready && mem_rvalid);
    rd_err  = wait_rv ? (mem_rvalid && mem_err) : (mem_ready && mem_err);
  end

  for (genvar e = 0; e < NC; e++) begin : g_cell
    localparam int R = e / N2;
    localparam int C = e % N2;
    logic signed [2*D_W-1:0] prod;
    assign prod = a_reg[R] * b_reg[C];
`ifdef NOC_MM_SAT_EN
    logic signed [D_W_ACC:0] sum;
    assign sum = (D_W_ACC+1)'(acc[e]) + (D_W_ACC+1)'(prod);
    assign acc_nxt[e] = (sum[D_W_ACC] != sum[D_W_ACC-1]) ?
                        (sum[D_W_ACC] ? {1'b1, {(D_W_ACC-1){1'b0}}} : {1'b0, {(D_W_ACC-1){1'b1}}}) :
                        sum[D_W_ACC-1:0];
`else
    assign acc_nxt[e] = acc[e] + D_W_ACC'(prod);
`endif
  end

  // Control FSM: sequences tile loads, MAC steps and stores, with registered bus outputs
  always_ff @(posedge clk_pl) begin
    if (rst_pl) begin
      state <= S_IDLE; done <= 1'b0; error <= 1'b0;
      mem_req <= 1'b0; mem_we <= 1'b0; mem_addr <= '0; mem_wdata <= '0;
      m1_q <= '0; m2_q <= '0; m3_q <= '0; i0 <= '0; j0 <= '0; k <= '0;
      base_a <= '0; base_b <= '0; base_d <= '0; idx <= '0; wait_rv <= 1'b0;
      for (int r = 0; r < N1; r++) a_reg[r] <= '0;
      for (int c = 0; c < N2; c++) b_reg[c] <= '0;
      for (int e = 0; e < NC; e++) acc[e] <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          m1_q <= M1; m2_q <= M2; m3_q <= M3;
          base_a <= addr_matrix_a; base_b <= addr_matrix_b; base_d <= addr_matrix_d;
          error <= 1'b0;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (m1_q == '0 || m2_q == '0 || m3_q == '0 ||
              (m1_q % MS_N1) != '0 || (m3_q % MS_N2) != '0) begin
            state <= S_DONE; done <= 1'b1; error <= 1'b1;
          end else begin
            i0 <= '0; j0 <= '0; k <= '0; idx <= '0;
            for (int e = 0; e < NC; e++) acc[e] <= '0;
            mem_req <= 1'b1; mem_we <= 1'b0; mem_addr <= base_a;
            state <= S_LOAD_A;
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (rd_err) begin
            state <= S_DONE; done <= 1'b1; error <= 1'b1; mem_req <= 1'b0; wait_rv <= 1'b0;
          end else if (rd_take) begin
            wait_rv <= 1'b0;
            mem_req <= 1'b1;
            if (state == S_LOAD_A) begin
              for (int r = 0; r < N1; r++) if (idx == IDX_W'(r)) a_reg[r] <= mem_rdata;
              if (idx == LAST_A) begin
                idx <= '0; state <= S_LOAD_B; mem_addr <= b_addr(k, j0);
              end else begin
                idx <= nidx; mem_addr <= a_addr(i0 + MATRIXSIZE_W'(nidx), k);
              end
            end else begin
              for (int c = 0; c < N2; c++) if (idx == IDX_W'(c)) b_reg[c] <= mem_rdata;
              if (idx == LAST_B) begin
                idx <= '0; state <= S_MAC; mem_req <= 1'b0;
              end else begin
                idx <= nidx; mem_addr <= b_addr(k, j0 + MATRIXSIZE_W'(nidx));
              end
            end
          end else if (!wait_rv && mem_ready) begin
            mem_req <= 1'b0; wait_rv <= 1'b1;
          end
        end
        S_MAC: begin
          for (int e = 0; e < NC; e++) acc[e] <= acc_nxt[e];
          mem_req <= 1'b1;
          if (k == m2_q - MS_1) begin
            state <= S_STORE; mem_we <= 1'b1;
            mem_addr <= st_addr('0); mem_wdata <= acc_nxt[0];
          end else begin
            k <= k + MS_1; state <= S_LOAD_A;
            mem_addr <= a_addr(i0, k + MS_1);
          end
        end
        S_STORE: if (mem_ready) begin
          if (mem_err) begin
            state <= S_DONE; done <= 1'b1; error <= 1'b1; mem_req <= 1'b0; mem_we <= 1'b0;
          end else if (idx != LAST_D) begin
            idx <= nidx; mem_addr <= st_addr(nidx); mem_wdata <= st_data;
          end else begin
            mem_we <= 1'b0; idx <= '0; k <= '0;
            for (int e = 0; e < NC; e++) acc[e] <= '0;
            if (last_col && last_row) begin
              state <= S_DONE; done <= 1'b1; mem_req <= 1'b0;
            end else begin
              state <= S_LOAD_A;
              if (last_col) begin
                i0 <= i0 + MS_N1; j0 <= '0; mem_addr <= a_addr(i0 + MS_N1, '0);
              end else begin
                j0 <= j0 + MS_N2; mem_addr <= a_addr(i0, '0);
              end
            end
          end
        end
        S_DONE: begin
          done <= 1'b0; state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_matmul_wrapper.sv
// Directed bench for noc_matmul_wrapper with a byte memory model and a second 16-bit accumulator instance.
// Covers identity/negative runs, dimension errors, fabric error abort, mid-run start and reset.
// The memory model can answer with zero latency or with stalls and delayed read data.
module tb_noc_matmul_wrapper;
  localparam int MW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, done, error;
  logic [MW-1:0] m1, m2, m3;
  logic [63:0] aa, ab, ad;
  logic mem_req, mem_we, mem_ready, mem_rvalid, mem_err;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_rdata;

  logic start16, done16, error16, req16, we16;
  logic [63:0] addr16;
  logic [15:0] wdata16;

  noc_matmul_wrapper dut (
    .clk_pl(clk), .rst_pl(rst), .start(start), .done(done), .error(error),
    .M1(m1), .M2(m2), .M3(m3),
    .addr_matrix_a(aa), .addr_matrix_b(ab), .addr_matrix_d(ad),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  noc_matmul_wrapper #(.D_W_ACC(16)) dut16 (
    .clk_pl(clk), .rst_pl(rst), .start(start16), .done(done16), .error(error16),
    .M1(m1), .M2(m2), .M3(m3),
    .addr_matrix_a(aa), .addr_matrix_b(ab), .addr_matrix_d(ad),
    .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
    .mem_ready(req16), .mem_rvalid(req16 && !we16), .mem_rdata(8'd127), .mem_err(1'b0)
  );

  // Memory model state
  logic [7:0]  a_mem [256];
  logic [7:0]  b_mem [256];
  int          lat = 0;
  int          err_at = -1;
  int          rd_n = 0, wr_n = 0, done_cnt = 0, w16_n = 0;
  logic [63:0] wr_addr [256];
  logic [31:0] wr_data [256];
  logic [63:0] w16_addr [8];
  logic [15:0] w16_data [8];
  logic        tog = 1'b0, pend_vld = 1'b0;
  logic [7:0]  pend_dat = 8'h00;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_addr = '0;

  int cmp_n = 0, err_n = 0;

  function automatic logic [7:0] peek(input logic [63:0] a);
    if (a[31:28] == 4'h1) return a_mem[a[7:0]];
    if (a[31:28] == 4'h2) return b_mem[a[7:0]];
    return 8'h00;
  endfunction

  always_comb begin
    if (lat == 0) begin
      mem_ready  = mem_req;
      mem_rvalid = mem_req && !mem_we;
      mem_rdata  = peek(mem_addr);
    end else begin
      mem_ready  = mem_req && tog;
      mem_rvalid = pend_vld;
      mem_rdata  = pend_dat;
    end
    mem_err = (err_at >= 0) && mem_req && mem_ready && !mem_we && (rd_n == err_at);
  end

  always @(posedge clk) begin
    prev_stall <= mem_req && !mem_ready && !rst;
    prev_addr  <= mem_addr;
    if (rst) begin
      tog <= 1'b0; pend_vld <= 1'b0;
    end else begin
      tog <= ~tog; pend_vld <= 1'b0;
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          wr_addr[wr_n[7:0]] <= mem_addr; wr_data[wr_n[7:0]] <= mem_wdata; wr_n <= wr_n + 1;
        end else begin
          rd_n <= rd_n + 1; pend_vld <= 1'b1; pend_dat <= peek(mem_addr);
        end
      end
      if (done) done_cnt <= done_cnt + 1;
      if (req16 && we16) begin
        w16_addr[w16_n[2:0]] <= addr16; w16_data[w16_n[2:0]] <= wdata16; w16_n <= w16_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A stalled request must present the same request and address next cycle
  always @(negedge clk) begin
    if (prev_stall && !rst) begin
      check("hold_req", {63'd0, mem_req}, 64'd1);
      check("hold_addr", mem_addr, prev_addr);
    end
  end

  task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic [MW-1:0] c);
    m1 = a; m2 = b; m3 = c;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    check({tag, "_done"}, {63'd0, done}, 64'd1);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < 256; i++) begin a_mem[i] = 8'h00; b_mem[i] = 8'h00; end
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a_mem[i*4+k] = (i == k) ? 8'd1 : 8'd0;
        b_mem[i*4+k] = 8'(4*i + k);
      end
  endtask

  task automatic check_tiles(input string tag, input int wr0, input logic [31:0] cval, input bit use_c);
    int n = 0;
    for (int ti = 0; ti < 2; ti++)
      for (int tj = 0; tj < 2; tj++)
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++) begin
            int i = 2*ti + r;
            int j = 2*tj + c;
            check({tag, "_addr"}, wr_addr[wr0+n], 64'h3000_0000 + 64'(4*(i*4 + j)));
            check({tag, "_data"}, {32'd0, wr_data[wr0+n]}, {32'd0, use_c ? cval : 32'(4*i + j)});
            n++;
          end
  endtask

  initial begin
    int rd0, wr0, dc0, w6;
    logic [15:0] sat_exp;
    logic [31:0] t7_exp [4];
    rst = 1'b1; start = 1'b0; start16 = 1'b0;
    m1 = '0; m2 = '0; m3 = '0;
    aa = 64'h1000_0000; ab = 64'h2000_0000; ad = 64'h3000_0000;
    repeat (3) @(negedge clk);
    check("rst_done",  {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_req",   {63'd0, mem_req}, 64'd0);
    check("rst_we",    {63'd0, mem_we}, 64'd0);
    check("rst_addr",  mem_addr, 64'd0);
    check("rst_wdata", {32'd0, mem_wdata}, 64'd0);
    rst = 1'b0;

    // 1: identity A, zero-latency memory: D equals B
    fill_identity();
    rd0 = rd_n; wr0 = wr_n; dc0 = done_cnt;
    launch(4, 4, 4);
    check("t1_req_early", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    check("t1_req_at2", {63'd0, mem_req}, 64'd1);
    check("t1_first_addr", mem_addr, 64'h1000_0000);
    wait_done(400, "t1");
    check("t1_error", {63'd0, error}, 64'd0);
    repeat (3) @(negedge clk);
    check("t1_done_pulses", 64'(done_cnt - dc0), 64'd1);
    check("t1_reads", 64'(rd_n - rd0), 64'd64);
    check("t1_writes", 64'(wr_n - wr0), 64'd16);
    check_tiles("t1", wr0, 32'd0, 1'b0);

    // 2: A=-1, B=3 with stalling memory, plus an ignored mid-run start
    for (int i = 0; i < 256; i++) begin a_mem[i] = 8'hFF; b_mem[i] = 8'd3; end
    lat = 1;
    wr0 = wr_n; dc0 = done_cnt;
    launch(4, 4, 4);
    repeat (20) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done(2000, "t2");
    check("t2_error", {63'd0, error}, 64'd0);
    repeat (3) @(negedge clk);
    check("t2_done_pulses", 64'(done_cnt - dc0), 64'd1);
    check("t2_writes", 64'(wr_n - wr0), 64'd16);
    check_tiles("t2", wr0, 32'hFFFF_FFF4, 1'b1);
    lat = 0;

    // 3: M2=0 rejected, done two cycles after start
    rd0 = rd_n; wr0 = wr_n;
    launch(4, 0, 4);
    check("t3_done_early", {63'd0, done}, 64'd0);
    @(negedge clk);
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_error", {63'd0, error}, 64'd1);
    @(negedge clk);
    check("t3_done_drop", {63'd0, done}, 64'd0);
    check("t3_error_hold", {63'd0, error}, 64'd1);
    check("t3_no_req", 64'((rd_n - rd0) + (wr_n - wr0)), 64'd0);

    // 4: M1 not a multiple of N1; accepted start clears the old error
    rd0 = rd_n; wr0 = wr_n;
    launch(3, 4, 4);
    check("t4_err_clear", {63'd0, error}, 64'd0);
    @(negedge clk);
    check("t4_done", {63'd0, done}, 64'd1);
    check("t4_error", {63'd0, error}, 64'd1);
    check("t4_no_req", 64'((rd_n - rd0) + (wr_n - wr0)), 64'd0);

    // 5: fabric error on the 5th read aborts with no writes
    fill_identity();
    rd0 = rd_n; wr0 = wr_n;
    err_at = rd_n + 4;
    launch(4, 4, 4);
    check("t5_err_clear", {63'd0, error}, 64'd0);
    wait_done(100, "t5");
    check("t5_error", {63'd0, error}, 64'd1);
    check("t5_reads", 64'(rd_n - rd0), 64'd5);
    check("t5_writes", 64'(wr_n - wr0), 64'd0);
    @(negedge clk);
    check("t5_req_after", {63'd0, mem_req}, 64'd0);
    err_at = -1;

    // 6: reset mid-run abandons the run
    launch(4, 4, 4);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_req_drop", {63'd0, mem_req}, 64'd0);
    check("t6_error", {63'd0, error}, 64'd0);
    w6 = wr_n;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_no_writes", 64'(wr_n - w6), 64'd0);
    check("t6_idle_req", {63'd0, mem_req}, 64'd0);

    // 7: engine restarts cleanly after reset: 2x1x2 single tile
    wr0 = wr_n;
    t7_exp[0] = 32'd0; t7_exp[1] = 32'd1; t7_exp[2] = 32'd0; t7_exp[3] = 32'd0;
    launch(2, 1, 2);
    check("t7_req_early", {63'd0, mem_req}, 64'd0);
    @(negedge clk);
    check("t7_req_at2", {63'd0, mem_req}, 64'd1);
    wait_done(100, "t7");
    check("t7_error", {63'd0, error}, 64'd0);
    check("t7_writes", 64'(wr_n - wr0), 64'd4);
    for (int n = 0; n < 4; n++) begin
      check("t7_addr", wr_addr[wr0+n], 64'h3000_0000 + 64'(4*n));
      check("t7_data", {32'd0, wr_data[wr0+n]}, {32'd0, t7_exp[n]});
    end

    // 8: 16-bit accumulator, A=B=127, M2=4
`ifdef NOC_MM_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'hFC04;
`endif
    m1 = 2; m2 = 4; m3 = 2;
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    begin
      int n = 0;
      while (!done16 && n < 200) begin @(negedge clk); n++; end
    end
    check("t8_done", {63'd0, done16}, 64'd1);
    check("t8_error", {63'd0, error16}, 64'd0);
    check("t8_writes", 64'(w16_n), 64'd4);
    for (int n = 0; n < 4; n++) begin
      check("t8_addr", w16_addr[n], 64'h3000_0000 + 64'(4*n));
      check("t8_data", {48'd0, w16_data[n]}, {48'd0, sat_exp});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
